// File: rtl/wall_scroller.sv
`default_nettype none
// ==== wall_scroller : per-frame erase/move/redraw of NUM_WALLS walls over a plot/plot_ready pixel stream ====
// ==== Rev 1.0 -- optional speed ramp with score under WALL_SPEEDUP_EN                                      ====
module wall_scroller #(
   parameter int         NUM_WALLS    = 2,
   parameter int         X_W          = 8,
   parameter int         Y_W          = 7,
   parameter int         SCREEN_W     = 160,
   parameter int         SCREEN_H     = 120,
   parameter int         WALL_X_START = 100,
   parameter int         WALL_SPACING = 80,
   parameter int         WALL_WIDTH   = 10,
   parameter int         GAP_H        = 40,
   parameter int         GAP_RESET    = 40,
   parameter int         SPEED        = 4,
   parameter int         PLAYER_X     = 20,
   parameter logic [2:0] WALL_COLOUR  = 3'b100,
   parameter logic [2:0] BG_COLOUR    = 3'b111
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       frame_tick,
   input  logic                       plot_ready,
   output logic                       plot,
   output logic [X_W-1:0]             x_out,
   output logic [Y_W-1:0]             y_out,
   output logic [2:0]                 colour_out,
   output logic                       busy,
   output logic [7:0]                 score_out,
   output logic [NUM_WALLS*X_W-1:0]   wall_x_flat,
   output logic [NUM_WALLS*Y_W-1:0]   gap_y_flat
);
   localparam int c_IW      = (NUM_WALLS > 1) ? $clog2(NUM_WALLS) : 1;
   localparam int c_CXW     = $clog2(WALL_WIDTH + 1);
   localparam int c_GAP_LIM = SCREEN_H - GAP_H;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ERASE = 3'd1,
      S_MOVE  = 3'd2,
      S_DRAW  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t           r_state;
   logic [c_IW-1:0]  r_idx;
   logic [c_CXW-1:0] r_cx;
   logic [Y_W-1:0]   r_cy;
   logic             r_last;
   logic [X_W-1:0]   r_wx [NUM_WALLS];
   logic [Y_W-1:0]   r_gy [NUM_WALLS];
   logic [7:0]       r_score;
   logic [7:0]       r_lfsr;
   logic             r_plot;
   logic [X_W-1:0]   r_x;
   logic [Y_W-1:0]   r_y;
   logic [2:0]       r_colour;
   logic             r_busy;

   logic [X_W-1:0]   w_wx;
   logic [Y_W-1:0]   w_gy;
   logic [X_W:0]     w_px;
   logic [Y_W:0]     w_cy_ext;
   logic [Y_W:0]     w_gy_ext;
   logic             w_in_gap;
   logic             w_visible;
   logic             w_pix_last;
   logic             w_free;
   logic [X_W-1:0]   w_speed;
   logic             w_can;
   logic [X_W-1:0]   w_new_x;
   logic [X_W:0]     w_old_end;
   logic [X_W:0]     w_new_end;
   logic             w_score_hit;
   logic             w_score_inc;
   logic [7:0]       w_rnd;
   logic [7:0]       w_gap_sub;
   logic             w_fb;

   assign w_wx       = r_wx[r_idx];
   assign w_gy       = r_gy[r_idx];
   assign w_px       = {1'b0, w_wx} + (X_W+1)'(r_cx);
   assign w_cy_ext   = {1'b0, r_cy};
   assign w_gy_ext   = {1'b0, w_gy};
   assign w_in_gap   = (w_cy_ext >= w_gy_ext) && (w_cy_ext < w_gy_ext + (Y_W+1)'(GAP_H));
   assign w_visible  = (w_px < (X_W+1)'(SCREEN_W)) && !((r_state == S_DRAW) && w_in_gap);
   assign w_pix_last = (r_cx == c_CXW'(WALL_WIDTH - 1)) && (r_cy == Y_W'(SCREEN_H - 1));
   // The scan may step whenever no pixel is pending or the pending one is being accepted.
   assign w_free     = !r_plot || plot_ready;

   assign w_can       = (w_wx >= w_speed);
   assign w_new_x     = w_can ? (w_wx - w_speed) : X_W'(SCREEN_W);
   assign w_old_end   = {1'b0, w_wx} + (X_W+1)'(WALL_WIDTH);
   assign w_new_end   = {1'b0, w_new_x} + (X_W+1)'(WALL_WIDTH);
   assign w_score_hit = (w_old_end > (X_W+1)'(PLAYER_X)) && (w_new_end <= (X_W+1)'(PLAYER_X));
   assign w_score_inc = (r_state == S_MOVE) && w_score_hit && (r_score != 8'hFF);
   assign w_rnd       = {1'b0, r_lfsr[6:0]};
   assign w_gap_sub   = (w_rnd >= 8'(c_GAP_LIM)) ? (w_rnd - 8'(c_GAP_LIM)) : w_rnd;
   assign w_fb        = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

`ifdef WALL_SPEEDUP_EN
   logic [X_W-1:0] r_speed;
   logic [X_W-1:0] r_speed_nxt;

   // r_speed_nxt tracks the ramp; r_speed only picks it up at the start of a pass.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_speed     <= X_W'(SPEED);
         r_speed_nxt <= X_W'(SPEED);
      end else begin
         if (w_score_inc && (r_score[2:0] == 3'd7) && (r_speed_nxt < X_W'(2 * SPEED)))
            r_speed_nxt <= r_speed_nxt + 1'b1;
         if ((r_state == S_IDLE) && frame_tick)
            r_speed <= r_speed_nxt;
      end
   end
   assign w_speed = r_speed;
`else
   assign w_speed = X_W'(SPEED);
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_idx    <= '0;
         r_cx     <= '0;
         r_cy     <= '0;
         r_last   <= 1'b0;
         r_score  <= 8'd0;
         r_lfsr   <= 8'hA5;
         r_plot   <= 1'b0;
         r_x      <= '0;
         r_y      <= '0;
         r_colour <= 3'd0;
         r_busy   <= 1'b0;
         for (int i = 0; i < NUM_WALLS; i++) begin
            r_wx[i] <= X_W'(WALL_X_START + i * WALL_SPACING);
            r_gy[i] <= Y_W'(GAP_RESET);
         end
      end else begin
         r_lfsr <= {r_lfsr[6:0], w_fb};
         case (r_state)
            S_IDLE: begin
               if (frame_tick) begin
                  r_idx   <= '0;
                  r_cx    <= '0;
                  r_cy    <= '0;
                  r_last  <= 1'b0;
                  r_busy  <= 1'b1;
                  r_state <= S_ERASE;
               end
            end
            S_ERASE, S_DRAW: begin
               if (w_free) begin
                  if (r_last) begin
                     r_plot <= 1'b0;
                     r_cx   <= '0;
                     r_cy   <= '0;
                     r_last <= 1'b0;
                     if (r_state == S_ERASE)
                        r_state <= S_MOVE;
                     else if (r_idx == c_IW'(NUM_WALLS - 1))
                        r_state <= S_DONE;
                     else begin
                        r_idx   <= r_idx + 1'b1;
                        r_state <= S_ERASE;
                     end
                  end else begin
                     r_plot   <= w_visible;
                     r_x      <= w_px[X_W-1:0];
                     r_y      <= r_cy;
                     r_colour <= (r_state == S_DRAW) ? WALL_COLOUR : BG_COLOUR;
                     if (w_pix_last)
                        r_last <= 1'b1;
                     else if (r_cx == c_CXW'(WALL_WIDTH - 1)) begin
                        r_cx <= '0;
                        r_cy <= r_cy + 1'b1;
                     end else
                        r_cx <= r_cx + 1'b1;
                  end
               end
            end
            S_MOVE: begin
               r_wx[r_idx] <= w_new_x;
               if (!w_can)
                  r_gy[r_idx] <= Y_W'(w_gap_sub);
               if (w_score_inc)
                  r_score <= r_score + 1'b1;
               r_state <= S_DRAW;
            end
            S_DONE: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   for (genvar g = 0; g < NUM_WALLS; g++) begin : g_flat
      assign wall_x_flat[g*X_W +: X_W] = r_wx[g];
      assign gap_y_flat[g*Y_W +: Y_W]  = r_gy[g];
   end

   assign plot       = r_plot;
   assign x_out      = r_x;
   assign y_out      = r_y;
   assign colour_out = r_colour;
   assign busy       = r_busy;
   assign score_out  = r_score;
endmodule
`default_nettype wire

// File: tb/tb_wall_scroller.sv
`default_nettype none
// ==== tb_wall_scroller : pixel-stream and wall-state checks of wall_scroller against a rule-level model ====
// ==== Rev 1.0                                                                                            ====
module tb_wall_scroller;
   localparam int         NW  = 2;
   localparam int         XW  = 8;
   localparam int         YW  = 7;
   localparam int         SW  = 160;
   localparam int         SH  = 40;
   localparam int         XS  = 100;
   localparam int         SP  = 80;
   localparam int         WW  = 10;
   localparam int         GH  = 16;
   localparam int         GR  = 12;
   localparam int         SPD = 4;
   localparam int         PX  = 20;
   localparam logic [2:0] WC  = 3'b100;
   localparam logic [2:0] BG  = 3'b111;

   logic              clk = 1'b0;
   logic              reset;
   logic              frame_tick;
   logic              plot_ready;
   logic              plot;
   logic [XW-1:0]     x_out;
   logic [YW-1:0]     y_out;
   logic [2:0]        colour_out;
   logic              busy;
   logic [7:0]        score_out;
   logic [NW*XW-1:0]  wall_x_flat;
   logic [NW*YW-1:0]  gap_y_flat;

   wall_scroller #(
      .SCREEN_H  (SH),
      .GAP_H     (GH),
      .GAP_RESET (GR)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .frame_tick  (frame_tick),
      .plot_ready  (plot_ready),
      .plot        (plot),
      .x_out       (x_out),
      .y_out       (y_out),
      .colour_out  (colour_out),
      .busy        (busy),
      .score_out   (score_out),
      .wall_x_flat (wall_x_flat),
      .gap_y_flat  (gap_y_flat)
   );

   always #5 clk = ~clk;

   // Reference pseudo-random source: x^8+x^6+x^5+x^4+1, one step per clock.
   logic [7:0] m_lfsr;
   always @(posedge clk or posedge reset) begin
      if (reset) m_lfsr <= 8'hA5;
      else       m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
   end

   int          errors = 0;
   int          checks = 0;
   int          mx [NW];
   int          mg [NW];
   int          mscore;
   logic [17:0] exp_q [$];
   logic [17:0] obs_q [$];
   int          ready_mode;
   int          cyc;
   logic        hold_pend;
   logic [17:0] held;
   int          stab_err;
   logic [7:0]  lfsr_seen;
   logic [7:0]  mv_lfsr [NW];
   logic [XW-1:0] last_wx [NW];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NW; i++) begin
         mx[i]      = XS + i * SP;
         mg[i]      = GR;
         last_wx[i] = XW'(XS + i * SP);
      end
      mscore    = 0;
      hold_pend = 1'b0;
   endtask

   // One clock: observe at the falling edge, then drive plot_ready for the next rising edge.
   task automatic step();
      @(negedge clk);
      if (hold_pend && !(plot && ({x_out, y_out, colour_out} == held))) stab_err++;
      for (int i = 0; i < NW; i++)
         if (wall_x_flat[i*XW +: XW] != last_wx[i]) begin
            mv_lfsr[i] = lfsr_seen;
            last_wx[i] = wall_x_flat[i*XW +: XW];
         end
      lfsr_seen = m_lfsr;
      case (ready_mode)
         0:       plot_ready = 1'b1;
         1:       plot_ready = (cyc % 3 == 0);
         default: plot_ready = ($urandom_range(3, 0) != 0);
      endcase
      cyc++;
      if (plot && plot_ready) obs_q.push_back({x_out, y_out, colour_out});
      hold_pend = plot && !plot_ready;
      held      = {x_out, y_out, colour_out};
   endtask

   task automatic model_pass();
      int old, nx, r;
      exp_q.delete();
      for (int w = 0; w < NW; w++) begin
         for (int y = 0; y < SH; y++)
            for (int x = 0; x < WW; x++)
               if (mx[w] + x < SW) exp_q.push_back({8'(mx[w] + x), 7'(y), BG});
         old = mx[w];
         if (old >= SPD) nx = old - SPD;
         else begin
            nx    = SW;
            r     = int'(mv_lfsr[w][6:0]);
            mg[w] = (r >= SH - GH) ? r - (SH - GH) : r;
         end
         if (old + WW > PX && nx + WW <= PX && mscore < 255) mscore++;
         mx[w] = nx;
         for (int y = 0; y < SH; y++)
            for (int x = 0; x < WW; x++)
               if (mx[w] + x < SW && !(y >= mg[w] && y < mg[w] + GH))
                  exp_q.push_back({8'(mx[w] + x), 7'(y), WC});
      end
   endtask

   task automatic check_state(input string tag);
      for (int i = 0; i < NW; i++) begin
         chk($sformatf("%s_wall%0d_x", tag, i), 32'(wall_x_flat[i*XW +: XW]), 32'(mx[i]));
         chk($sformatf("%s_wall%0d_gap", tag, i), 32'(gap_y_flat[i*YW +: YW]), 32'(mg[i]));
      end
      chk({tag, "_score"}, 32'(score_out), 32'(mscore));
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_plot"}, 32'(plot), 32'd0);
   endtask

   task automatic run_pass(input int mode, input int extra_tick, input string tag);
      int n;
      int mism;
      logic lat_chk;
      obs_q.delete();
      stab_err   = 0;
      ready_mode = mode;
      cyc        = 0;
      lat_chk    = (mx[0] < SW);
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      chk({tag, "_lat1_plot"}, 32'(plot), 32'd0);
      chk({tag, "_lat1_busy"}, 32'(busy), 32'd1);
      step();
      if (lat_chk) chk({tag, "_lat2_plot"}, 32'(plot), 32'd1);
      n = 0;
      while (busy && n < 20000) begin
         if (n == extra_tick) frame_tick = 1'b1;
         step();
         frame_tick = 1'b0;
         n++;
      end
      chk({tag, "_timeout"}, 32'(busy), 32'd0);
      model_pass();
      chk({tag, "_pix_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
      mism = 0;
      for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++)
         if (obs_q[k] !== exp_q[k]) mism++;
      chk({tag, "_pix_mismatch"}, 32'(mism), 32'd0);
      chk({tag, "_hold_stable"}, 32'(stab_err), 32'd0);
      check_state(tag);
   endtask

   initial begin
      int n;
      int plots;
      reset      = 1'b1;
      frame_tick = 1'b0;
      plot_ready = 1'b0;
      ready_mode = 0;
      cyc        = 0;
      lfsr_seen  = 8'h00;
      stab_err   = 0;
      model_reset();
      step();
      step();
      reset = 1'b0;
      step();
      check_state("reset");
      chk("reset_xout", 32'(x_out), 32'd0);
      chk("reset_colour", 32'(colour_out), 32'd0);

      run_pass(0, -1, "pass_ready_high");
      run_pass(1, -1, "pass_ready_1of3");
      for (int p = 3; p <= 27; p++) begin
         n = $urandom_range(3, 0);
         for (int k = 0; k < n; k++) step();
         run_pass(2, -1, $sformatf("pass%0d", p));
      end
      chk("wrap_wall0_x", 32'(wall_x_flat[0 +: XW]), 32'd156);
      chk("wrap_wall1_x", 32'(wall_x_flat[XW +: XW]), 32'd72);
      chk("score_single_cross", 32'(score_out), 32'd1);

      // Abort in the middle of a DRAW scan.
      ready_mode = 0;
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      for (int k = 0; k < WW * SH + 6; k++) step();
      n = 0;
      while (!plot && n < 200) begin
         step();
         n++;
      end
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("abort_plot", 32'(plot), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_y", 32'(y_out), 32'd0);
      step();
      step();
      reset = 1'b0;
      model_reset();
      plots = 0;
      for (int k = 0; k < 5; k++) begin
         step();
         if (plot) plots++;
      end
      chk("abort_no_plot", 32'(plots), 32'd0);
      check_state("abort");

      run_pass(2, 50, "pass_tick_while_busy");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
